// File: rtl/pcm_expand_sched_if.sv
// Request and output bundle for pcm_expand_sched: per-channel log PCM requests
// in, tagged linear samples out. The scheduler connects through the slave modport.
interface pcm_expand_sched_if #(
    parameter int NCH = 4,
    parameter int CHW = 2
);
    // Valid/ready: a word moves on a rising clk edge where valid and ready are
    // both high; valid and its data stay stable until that edge, and ready may
    // be asserted or withdrawn at any time without affecting valid.
    logic [NCH-1:0]   req_valid;
    logic [NCH*8-1:0] req_data;
    logic [NCH-1:0]   req_ready;
    logic             out_valid;
    logic [12:0]      out_data;
    logic [CHW-1:0]   out_chan;
    logic             out_ready;

    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_data, out_chan
    );

    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_data, out_chan
    );
endinterface

// File: rtl/pcm_expand_sched.sv
// Round-robin scheduler sharing one combinational PCM expander among NCH channels.
// Build option PCM_EVEN_INVERT_EN undoes A-law even-bit inversion (xor 8'h55) on load.
module pcm_expand_sched #(
    parameter int NCH = 4,
    parameter int CHW = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    pcm_expand_sched_if.slave bus,
    output logic [7:0]        exp_log,
    input  logic [12:0]       exp_lin
);

`ifdef PCM_EVEN_INVERT_EN
    localparam logic [7:0] INV_MASK = 8'h55;
`else
    localparam logic [7:0] INV_MASK = 8'h00;
`endif

    logic           s1_valid;
    logic [CHW-1:0] s1_chan;
    logic [CHW-1:0] rr_ptr;
    logic           out_valid_q;
    logic [12:0]    out_data_q;
    logic [CHW-1:0] out_chan_q;

    logic           s2_free;
    logic           s1_adv;
    logic           s1_free;
    logic           grant_hit;
    logic [CHW-1:0] grant_chan;
    logic [CHW-1:0] scan_idx;
    logic [NCH-1:0] req_ready_c;
    logic           xfer;

    assign s2_free = !out_valid_q || bus.out_ready;
    assign s1_adv  = s1_valid && s2_free;
    assign s1_free = !s1_valid || s1_adv;

    // Search starts just after the last granted channel, wrapping at NCH-1.
    always_comb begin
        grant_hit  = 1'b0;
        grant_chan = '0;
        scan_idx   = '0;
        for (int k = 1; k <= NCH; k++) begin
            scan_idx = CHW'((int'(rr_ptr) + k) % NCH);
            if (!grant_hit && bus.req_valid[scan_idx]) begin
                grant_hit  = 1'b1;
                grant_chan = scan_idx;
            end
        end
    end

    always_comb begin
        req_ready_c = '0;
        if (s1_free && grant_hit) begin
            req_ready_c[grant_chan] = 1'b1;
        end
    end

    assign xfer = s1_free && grant_hit;

    // Stage 1: exp_log only changes on a transfer so the expander input is quiet when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_chan  <= '0;
            exp_log  <= 8'h00;
            rr_ptr   <= CHW'(NCH - 1);
        end else if (xfer) begin
            s1_valid <= 1'b1;
            s1_chan  <= grant_chan;
            exp_log  <= bus.req_data[{grant_chan, 3'b000} +: 8] ^ INV_MASK;
            rr_ptr   <= grant_chan;
        end else if (s1_free) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2: output register, refilled in the same cycle it is drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
        end else if (s1_adv) begin
            out_valid_q <= 1'b1;
            out_data_q  <= exp_lin;
            out_chan_q  <= s1_chan;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_chan  = out_chan_q;

endmodule

// File: tb/tb_pcm_expand_sched.sv
// Bench for pcm_expand_sched: a transaction-level reference (FIFO of in-flight
// samples with one-cycle latency, last-grant round robin) checked every cycle.
module tb_pcm_expand_sched;

    localparam int NCH = 4;
    localparam int CHW = 2;

`ifdef PCM_EVEN_INVERT_EN
    localparam logic [7:0]  INV_MASK = 8'h55;
    localparam logic [7:0]  FEAT_LOG = 8'h7F;
    localparam logic [12:0] FEAT_LIN = 13'h0FC0;
`else
    localparam logic [7:0]  INV_MASK = 8'h00;
    localparam logic [7:0]  FEAT_LOG = 8'h2A;
    localparam logic [12:0] FEAT_LIN = 13'h006A;
`endif

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  exp_log;
    logic [12:0] exp_lin;

    always #5 clk = ~clk;

    pcm_expand_sched_if #(.NCH(NCH), .CHW(CHW)) bus ();

    pcm_expand_sched #(.NCH(NCH), .CHW(CHW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .exp_log (exp_log),
        .exp_lin (exp_lin)
    );

    // A-law style segment/mantissa expansion, sign kept in bit 12.
    function automatic logic [12:0] expand(input logic [7:0] c);
        int seg;
        int mant;
        int mag;
        seg  = int'(c[6:4]);
        mant = int'(c[3:0]);
        if (seg == 0) mag = 2 * mant + 1;
        else          mag = (2 * mant + 33) << (seg - 1);
        return {c[7], mag[11:0]};
    endfunction

    assign exp_lin = expand(exp_log);

    // ---------------- scoreboard / model state ----------------
    logic [CHW+12:0] exp_q[$];
    int              stamp_q[$];
    logic [CHW+12:0] seen_q[$];
    int              seen_t[$];
    int              grant_q[$];
    int              edge_cnt;
    int              last_grant;
    logic [7:0]      last_code;

    bit              acc_hit;
    int              acc_chan;
    logic [7:0]      acc_code;
    bit              cons_hit;
    logic [NCH-1:0]  acc_mask;

    logic [NCH-1:0]  dut_rdy_s;
    logic            dut_ov_s;
    logic [12:0]     dut_od_s;
    logic [CHW-1:0]  dut_oc_s;
    logic [7:0]      dut_log_s;

    int n_pass;
    int n_total;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        exp_q.delete();
        stamp_q.delete();
        seen_q.delete();
        seen_t.delete();
        grant_q.delete();
        last_grant = NCH - 1;
        last_code  = 8'h00;
    endtask

    // Compare process: runs at the falling edge, inputs are stable then.
    task automatic check_cycle();
        logic [NCH-1:0]  er;
        logic [CHW+12:0] head;
        bit              ok;
        bit              eov;
        int              c;
        er       = '0;
        acc_hit  = 1'b0;
        acc_chan = 0;
        acc_code = 8'h00;
        ok = (exp_q.size() < 2) || (bus.out_ready == 1'b1);
        if (ok) begin
            for (int k = 1; k <= NCH; k++) begin
                c = (last_grant + k) % NCH;
                if (!acc_hit && bus.req_valid[c]) begin
                    acc_hit  = 1'b1;
                    acc_chan = c;
                    er[c]    = 1'b1;
                    acc_code = bus.req_data[8*c +: 8] ^ INV_MASK;
                end
            end
        end
        eov      = (exp_q.size() > 0) && (stamp_q[0] < edge_cnt);
        cons_hit = eov && bus.out_ready;

        chk("req_ready", 32'(bus.req_ready), 32'(er));
        chk("out_valid", 32'(bus.out_valid), 32'(eov));
        chk("exp_log", 32'(exp_log), 32'(last_code));
        if (eov) begin
            head = exp_q[0];
            chk("out_data", 32'(bus.out_data), 32'(head[12:0]));
            chk("out_chan", 32'(bus.out_chan), 32'(head[CHW+12:13]));
        end

        dut_rdy_s = bus.req_ready;
        dut_ov_s  = bus.out_valid;
        dut_od_s  = bus.out_data;
        dut_oc_s  = bus.out_chan;
        dut_log_s = exp_log;
        acc_mask  = bus.req_ready & bus.req_valid;
        if (bus.out_valid && bus.out_ready) begin
            seen_q.push_back({bus.out_chan, bus.out_data});
            seen_t.push_back(edge_cnt);
        end
        for (int k = 0; k < NCH; k++) begin
            if (bus.req_ready[k]) grant_q.push_back(k);
        end
    endtask

    task automatic model_update();
        edge_cnt++;
        if (cons_hit) begin
            void'(exp_q.pop_front());
            void'(stamp_q.pop_front());
        end
        if (acc_hit) begin
            exp_q.push_back({CHW'(acc_chan), expand(acc_code)});
            stamp_q.push_back(edge_cnt);
            last_grant = acc_chan;
            last_code  = acc_code;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycle();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
        model_update();
    endtask

    task automatic do_reset();
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic set_code(input int ch, input logic [7:0] raw);
        bus.req_data[8*ch +: 8] = raw ^ INV_MASK;
    endtask

    task automatic drive_random(input int p_valid, input int p_ready);
        for (int i = 0; i < NCH; i++) begin
            if (acc_mask[i]) bus.req_valid[i] = 1'b0;
            if (!bus.req_valid[i] && $urandom_range(0, 99) < p_valid) begin
                bus.req_valid[i] = 1'b1;
                bus.req_data[8*i +: 8] = 8'($urandom);
            end
        end
        bus.out_ready = ($urandom_range(0, 99) < p_ready);
    endtask

    logic [12:0] lit_data[4];
    int          p_valid_tab[5];
    int          p_ready_tab[5];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_pass   = 0;
        n_total  = 0;
        edge_cnt = 0;
        acc_mask = '0;
        lit_data = '{13'h100B, 13'h006A, 13'h0FC0, 13'h0001};
        p_valid_tab = '{90, 30, 100, 60, 10};
        p_ready_tab = '{100, 50, 20, 90, 70};

        // Reset state, then a single ch0 sample of 8'h00.
        do_reset();
        cycle();
        chk("rst_out_valid", 32'(dut_ov_s), 32'd0);
        chk("rst_out_data", 32'(dut_od_s), 32'd0);
        chk("rst_out_chan", 32'(dut_oc_s), 32'd0);
        chk("rst_exp_log", 32'(dut_log_s), 32'd0);
        bus.out_ready = 1'b1;
        bus.req_valid = 4'b0001;
        set_code(0, 8'h00);
        cycle();
        chk("t1_grant", 32'(dut_rdy_s), 32'b0001);
        bus.req_valid = '0;
        cycle();
        chk("t1_ready_drop", 32'(dut_rdy_s), 32'd0);
        cycle();
        chk("t1_out_valid", 32'(dut_ov_s), 32'd1);
        chk("t1_out_data", 32'(dut_od_s), 32'h0001);
        chk("t1_out_chan", 32'(dut_oc_s), 32'd0);

        // All four channels at once: grants 0..3, outputs back-to-back.
        do_reset();
        set_code(0, 8'h85);
        set_code(1, 8'h2A);
        set_code(2, 8'h7F);
        set_code(3, 8'h00);
        bus.req_valid = 4'b1111;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 12 && seen_q.size() < 4; i++) begin
            cycle();
            bus.req_valid = bus.req_valid & ~acc_mask;
        end
        chk("t2_count", 32'(seen_q.size()), 32'd4);
        for (int i = 0; i < seen_q.size() && i < 4; i++) begin
            chk("t2_chan", 32'(seen_q[i][CHW+12:13]), 32'(i));
            chk("t2_data", 32'(seen_q[i][12:0]), 32'(lit_data[i]));
            chk("t2_b2b", 32'(seen_t[i] - seen_t[0]), 32'(i));
            chk("t2_grant", 32'(grant_q[i]), 32'(i));
        end

        // Channels 1 and 3 always valid: grants alternate.
        do_reset();
        bus.req_valid = 4'b1010;
        bus.req_data  = 32'($urandom);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle();
            for (int c = 0; c < NCH; c++) begin
                if (acc_mask[c]) bus.req_data[8*c +: 8] = 8'($urandom);
            end
        end
        chk("t3_grants", 32'(grant_q.size()), 32'd8);
        for (int i = 0; i < grant_q.size(); i++) begin
            chk("t3_alt", 32'(grant_q[i]), (i % 2 == 0) ? 32'd1 : 32'd3);
        end

        // Four-channel burst with out_ready held low for 5 cycles.
        do_reset();
        bus.req_valid = 4'b1111;
        bus.req_data  = 32'($urandom);
        for (int i = 0; i < 30 && seen_q.size() < 4; i++) begin
            bus.out_ready = !(i >= 1 && i < 6);
            cycle();
            bus.req_valid = bus.req_valid & ~acc_mask;
        end
        chk("t4_count", 32'(seen_q.size()), 32'd4);
        for (int i = 0; i < seen_q.size(); i++) begin
            chk("t4_order", 32'(seen_q[i][CHW+12:13]), 32'(i));
        end

        // Asynchronous reset while both stages are full.
        do_reset();
        bus.req_valid = 4'b1111;
        bus.req_data  = 32'($urandom);
        bus.out_ready = 1'b0;
        repeat (3) begin
            cycle();
            bus.req_valid = bus.req_valid & ~acc_mask;
        end
        chk("t5_pre_valid", 32'(bus.out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_async_valid", 32'(bus.out_valid), 32'd0);
        chk("t5_async_data", 32'(bus.out_data), 32'd0);
        do_reset();
        bus.req_valid = 4'b1111;
        bus.out_ready = 1'b1;
        cycle();
        chk("t5_first_grant", 32'(dut_rdy_s), 32'b0001);
        bus.req_valid = bus.req_valid & ~acc_mask;

        // Channel 2 sends raw 8'h2A (inversion applied only in the option build).
        do_reset();
        bus.req_valid = 4'b0100;
        bus.req_data[23:16] = 8'h2A;
        bus.out_ready = 1'b1;
        cycle();
        chk("t6_grant", 32'(dut_rdy_s), 32'b0100);
        bus.req_valid = '0;
        cycle();
        chk("t6_exp_log", 32'(dut_log_s), 32'(FEAT_LOG));
        cycle();
        chk("t6_out_data", 32'(dut_od_s), 32'(FEAT_LIN));
        chk("t6_out_chan", 32'(dut_oc_s), 32'd2);

        // Randomized traffic with varying load and backpressure.
        do_reset();
        for (int seg = 0; seg < 5; seg++) begin
            for (int i = 0; i < 400; i++) begin
                drive_random(p_valid_tab[seg], p_ready_tab[seg]);
                cycle();
            end
        end
        bus.req_valid = '0;
        bus.out_ready = 1'b1;
        repeat (6) cycle();
        chk("drain_idle", 32'(dut_ov_s), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pcm_expand_sched.md
Name: pcm_expand_sched

Overview:
- Time-shares one combinational PCM log-to-linear expander (8-bit log code in, 13-bit linear out) among NCH sample channels of the FSK receive path.
- Round-robin arbitrates channel requests and registers the selected log code onto the shared expander input.
- Captures the expander result and presents it, tagged with its channel number, on a valid/ready output port.

Parameters:
- NCH, 4, number of requesting channels (2..8).
- CHW, 2, channel-index width; must equal ceil(log2(NCH)).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NCH  per-channel sample valid.
- req_data  input  NCH*8  per-channel 8-bit log PCM code; channel i occupies bits [8i+7:8i].
- req_ready  output  NCH  per-channel accept strobe; one-hot or zero.
- exp_log  output  8  registered code driven to the shared expander.
- exp_lin  input  13  combinational linear result from the expander.
- out_valid  output  1  linear sample valid.
- out_data  output  13  linear sample.
- out_chan  output  CHW  channel that produced out_data.
- out_ready  input  1  downstream accept.

Behaviour:
- Reset (async on rst_n low, mid-operation included):
  - s1_valid=0, exp_log=8'h00.
  - out_valid=0, out_data=0, out_chan=0.
  - rr_ptr=NCH-1, so channel 0 has top priority first.
  - All in-flight samples are discarded.
- Pipeline, two register stages:
  - S1 holds s1_valid, exp_log, s1_chan.
  - S2 is the output register: out_valid, out_data, out_chan.
- Advance conditions:
  - s2_free = !out_valid | out_ready.
  - s1_adv = s1_valid & s2_free.
  - s1_free = !s1_valid | s1_adv.
- Arbitration (combinational):
  - When s1_free, grant the first channel with req_valid set, searching from rr_ptr+1 upward with wrap from NCH-1 to 0.
  - req_ready[g]=1 only for the granted channel g; all bits are 0 when there is no grant or when !s1_free.
  - req_ready is independent of out_ready beyond the s1_free term; it has no combinational dependence on req_data.
- Transfer occurs when req_valid[g] & req_ready[g]. At that edge:
  - exp_log <= req_data[g]
  - s1_chan <= g
  - s1_valid <= 1
  - rr_ptr <= g
- When S1 is free and there is no grant, s1_valid <= 0. exp_log holds its last value, so the expander input never toggles while idle.
- On s1_adv:
  - out_data <= exp_lin
  - out_chan <= s1_chan
  - out_valid <= 1
- When out_valid & out_ready and !s1_adv, out_valid <= 0.
- Latency: a sample accepted at edge k has out_valid high after edge k+1.
- Throughput: one sample per clock while out_ready stays high.
- Backpressure: when out_valid & !out_ready, S2 holds. S1 then holds as well if full, and req_ready drops to all-zero when S1 is full. No sample is lost or duplicated.
- Simultaneous consume and refill of S2 or S1 in one cycle is legal and required for full throughput.
- rr_ptr updates only on a transfer, never on a stall.

Optional Feature:
- Macro: PCM_EVEN_INVERT_EN (A-law line-code even-bit inversion).
- Defined: the code loaded into S1 is req_data[g] ^ 8'h55, so the inversion is undone before expansion.
- Undefined: req_data[g] is loaded unchanged.
- Timing and handshake are identical in both builds.

Test Plan:
- Reset, then ch0 only sends 8'h00 with out_ready=1 -> req_ready=4'b0001 for one cycle; two edges later out_valid=1, out_data=13'h0001, out_chan=0.
- All four channels valid at once, codes 8'h85, 8'h2A, 8'h7F, 8'h00, out_ready=1 -> grants in order 0,1,2,3 on consecutive cycles; outputs 13'h100B, 13'h006A, 13'h0FC0, 13'h0001 with out_chan 0..3, back-to-back.
- Channels 1 and 3 continuously valid -> grants alternate 1,3,1,3; channels 0 and 2 never get req_ready.
- out_ready held low 5 cycles during a four-channel burst -> out_valid and out_data stay stable; req_ready=0 while S1 is full; after release, all samples emerge in order with none lost or duplicated.
- rst_n pulsed low while S1 and S2 are full -> out_valid=0 immediately (asynchronous); after release, the first grant goes to channel 0.
- PCM_EVEN_INVERT_EN defined, ch2 sends 8'h2A -> exp_log=8'h7F, out_data=13'h0FC0, out_chan=2.
